// File: rtl/four_way_rr_arbiter.sv
// Round-robin arbiter for four requesters: one registered one-hot grant, held until
// the owner releases or withdraws, with a watchdog that revokes overlong holds.
module four_way_rr_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic       any_req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       revoked
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             revoked_q, revoked_d;

  logic       sel_found;
  logic [1:0] sel_idx;
  logic [1:0] cand;
  logic       owner_done;
  logic       owner_gone;
  logic       timeout;

  assign any_req = |req;

  // Scan from the pointer downwards in k so the nearest requester after ptr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign owner_done = done;
  assign owner_gone = ~req[gnt_id_q];
  assign timeout    = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    revoked_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d  = GRANT;
          gnt_d    = 4'b0001 << sel_idx;
          gnt_id_d = sel_idx;
          ptr_d    = sel_idx + 2'd1;
          cnt_d    = '0;
        end
      end
      GRANT: begin
        if (owner_done || owner_gone || timeout) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          gnt_id_d  = 2'd0;
          // A watchdog revoke is flagged only when the owner did not also let go.
          revoked_d = timeout && !owner_done && !owner_gone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'd0;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      revoked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      revoked_q <= revoked_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q == GRANT);
  assign revoked = revoked_q;

endmodule
